// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU command sequencer and its command FIFO.
package alu_pkg;

  localparam int CODE_W = 4;
  localparam int ANS_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    HOLD
  } state_e;

  typedef struct packed {
    logic              a;
    logic              b;
    logic [CODE_W-1:0] code;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO: single clock, power-of-two depth, head visible
// combinationally, pointers wrap naturally at DEPTH.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t push_data,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after it
  // has been written, and leaving it out keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives them to an external ALU one at a time, and
// presents each captured result through a valid/ready handshake.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_a,
  input  logic              cmd_b,
  input  logic [CODE_W-1:0] cmd_code,
  output logic              alu_a,
  output logic              alu_b,
  output logic [CODE_W-1:0] alu_code,
  input  logic [ANS_W-1:0]  alu_ans,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ANS_W-1:0]  res_data,
  output logic [CODE_W-1:0] res_code,
  output logic [7:0]        op_count
);

  state_e            state_q, state_d;
  cmd_t              alu_q, alu_d;
  logic              res_valid_q, res_valid_d;
  logic [ANS_W-1:0]  res_data_q, res_data_d;
  logic [CODE_W-1:0] res_code_q, res_code_d;
  logic [7:0]        op_count_q, op_count_d;

  cmd_t fifo_head;
  cmd_t push_data;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  assign push_data = '{a: cmd_a, b: cmd_b, code: cmd_code};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  alu_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_data(push_data),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    alu_d       = alu_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_code_d  = res_code_q;
    op_count_d  = op_count_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          alu_d   = fifo_head;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        res_data_d  = alu_ans;
        res_code_d  = alu_q.code;
        res_valid_d = 1'b1;
        pop         = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          op_count_d  = op_count_q + 8'd1;
          res_valid_d = 1'b0;
          // A push landing on an empty FIFO at this edge becomes the head.
          if (!fifo_empty) begin
            alu_d   = fifo_head;
            state_d = DRIVE;
          end else if (push) begin
            alu_d   = push_data;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_code_q  <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      alu_q       <= alu_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_code_q  <= res_code_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_a     = alu_q.a;
  assign alu_b     = alu_q.b;
  assign alu_code  = alu_q.code;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_code  = res_code_q;
  assign op_count  = op_count_q;

endmodule
